// File: rtl/fifo_buffer.sv
// Synchronous FIFO stage fed by control_fsm strobes.
// It reports occupancy back to the FSM and pulses overflow/underflow for rejected accesses.
module fifo_buffer #(
    parameter  int WIDTH = 8,
    parameter  int DEPTH = 8,
    localparam int ADDR  = $clog2(DEPTH)
) (
    input  logic             clock,
    input  logic             resetn,
    input  logic             wen,
    input  logic             ren,
    input  logic [WIDTH-1:0] data_in,
    output logic [WIDTH-1:0] data_out,
    output logic             full,
    output logic             empty,
    output logic [ADDR:0]    count,
    output logic             overflow,
    output logic             underflow
);

    localparam logic [ADDR:0]   COUNT_FULL = (ADDR + 1)'(DEPTH);
    localparam logic [ADDR-1:0] PTR_ONE    = ADDR'(1);
    localparam logic [ADDR:0]   COUNT_ONE  = (ADDR + 1)'(1);

    logic [WIDTH-1:0] mem [DEPTH];

    logic [ADDR-1:0]  wr_ptr_q,    wr_ptr_d;
    logic [ADDR-1:0]  rd_ptr_q,    rd_ptr_d;
    logic [ADDR:0]    count_q,     count_d;
    logic [WIDTH-1:0] data_out_q,  data_out_d;
    logic             overflow_q,  overflow_d;
    logic             underflow_q, underflow_d;

    logic wr_ok;
    logic rd_ok;

    // Acceptance is gated on the pre-edge flags only, so there is no fall-through path.
    assign full  = (count_q == COUNT_FULL);
    assign empty = (count_q == '0);
    assign wr_ok = wen & ~full;
    assign rd_ok = ren & ~empty;

    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        data_out_d  = data_out_q;
        overflow_d  = wen & full;
        underflow_d = ren & empty;

        if (wr_ok) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end
        if (rd_ok) begin
            rd_ptr_d   = rd_ptr_q + PTR_ONE;
            data_out_d = mem[rd_ptr_q];
        end

        case ({wr_ok, rd_ok})
            2'b10:   count_d = count_q + COUNT_ONE;
            2'b01:   count_d = count_q - COUNT_ONE;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            data_out_q  <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            data_out_q  <= data_out_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    // Storage is deliberately left out of reset; the pointers alone define what is valid.
    always_ff @(posedge clock) begin
        if (wr_ok) begin
            mem[wr_ptr_q] <= data_in;
        end
    end

    assign data_out  = data_out_q;
    assign count     = count_q;
    assign overflow  = overflow_q;
    assign underflow = underflow_q;

endmodule

// File: doc/fifo_buffer.md
Name: fifo_buffer

Overview:
Synchronous FIFO storage stage directly downstream of control_fsm. Consumes its single-cycle wen/ren strobes, stores or returns data words, and reports full/empty back to the FSM. Also flags rejected accesses so the board can show overflow or underflow on LEDs.

Parameters:
WIDTH, 8, data word width in bits.
DEPTH, 8, number of entries; must be a power of two and at least 2.
ADDR, log2(DEPTH) = 3, pointer width; derived, not overridden.

Ports:
clock      input   1          system clock; all state updates on rising edge.
resetn     input   1          asynchronous, active-low reset.
wen        input   1          write strobe from control_fsm; one word per high cycle.
ren        input   1          read strobe from control_fsm; one word per high cycle.
data_in    input   WIDTH      write data, sampled on a clock edge where wen=1.
data_out   output  WIDTH      registered read data.
full       output  1          high when count == DEPTH.
empty      output  1          high when count == 0.
count      output  ADDR+1     number of stored entries, 0..DEPTH.
overflow   output  1          one-cycle pulse when a write is rejected.
underflow  output  1          one-cycle pulse when a read is rejected.

Behaviour:
- Reset (resetn=0, asynchronous):
  - wr_ptr=0, rd_ptr=0, count=0.
  - data_out=0, overflow=0, underflow=0.
  - Therefore empty=1 and full=0.
  - Storage array is not reset.
  - Reset asserted mid-operation discards all contents immediately.
  - Release is synchronous to the next rising edge.
- full and empty are combinational decodes of the count register. They change in the same cycle as count, one edge after the accepted access.
- Write acceptance: wr_ok = wen & ~full.
  - On wr_ok: mem[wr_ptr] <= data_in; wr_ptr increments modulo DEPTH (natural ADDR-bit wrap).
- Read acceptance: rd_ok = ren & ~empty.
  - On rd_ok: data_out <= mem[rd_ptr]; rd_ptr increments modulo DEPTH.
  - Read latency is 1 clock: data_out is valid the edge after the ren cycle.
  - data_out holds its value when no read is accepted.
- count update:
  - wr_ok only: +1.
  - rd_ok only: -1.
  - both, or neither: unchanged.
- Simultaneous wen & ren:
  - Not full and not empty: both accepted; the read returns the oldest entry, not the word being written.
  - Empty: write accepted, read rejected (underflow pulses); count becomes 1.
  - Full: read accepted, write rejected (overflow pulses); count becomes DEPTH-1.
  - Gating uses pre-edge full/empty only. There is no bypass or fall-through.
- overflow is registered: it is 1 for exactly the cycle after an edge where wen & full; otherwise 0.
- underflow is registered: it is 1 for exactly the cycle after an edge where ren & empty; otherwise 0.
- Rejected accesses change no pointer, no count, and no data_out.
- wen/ren held high for N cycles perform N accesses. Pulse shaping is control_fsm's job, not this block's.
- Internal invariants, to be checked with assertions in the bench:
  - count == (wr_ptr - rd_ptr) mod DEPTH, except count == DEPTH when the pointers are equal and the FIFO is full.
  - full and empty are never both high.

Test Plan:
- Reset then idle: resetn low for 2 cycles, release -> empty=1, full=0, count=0, data_out=0x00, overflow=0, underflow=0.
- Fill: write 0x11,0x22,...,0x88 on 8 consecutive cycles -> count steps 1..8; full=1 the edge after the 8th write; empty=0 after the 1st.
- Overflow: with FIFO full, wen=1 data_in=0x99 for one cycle -> overflow=1 for one cycle, count stays 8; a later drain returns 0x11..0x88 with no 0x99.
- Drain and underflow:
  - ren for 8 cycles -> data_out=0x11..0x88 each one cycle after its ren; empty=1 after the 8th.
  - One further ren -> underflow=1 for one cycle, data_out stays 0x88.
- Wrap-around and simultaneous:
  - Write 5 words, read 3, then write 6 more (pointers wrap past 7) -> count=8, full=1.
  - Reads return words in order 4,5,6..11.
  - wen&ren when count=4 -> count stays 4, oldest word is returned.
  - wen&ren when empty -> count=1, underflow=1.
- Reset mid-operation: with count=5, assert resetn low between clock edges -> count=0, empty=1, data_out=0 immediately without waiting for an edge; the next write after release lands at address 0 and reads back correctly.
